// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port ids for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker with owner lock
// ports: req[1:0] requests, last = previous winner, lock = keep last winner if it still requests;
//        grant_valid = any request, grant_id = winning port
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  output logic       grant_valid,
  output logic       grant_id
);
  always_comb begin
    grant_valid = |req;
    grant_id    = (lock && req[last]) ? last :
                  (&req)              ? ~last :
                  req[PORT_LDR]       ? PORT_LDR : PORT_CPU;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between CPU (port 0) and loader (port 1)
// ports: clk, rst (async, active-high); rN_req/rN_rw/rN_addr/rN_wdata requests, rN_ack/rN_rdata responses;
//        mem_rw/mem_addr/mem_data to memory, mem_q from memory; busy = not idle, owner = current/last grantee
// optional: define MEM_ARB_LOCK_EN to add r0_lock/r1_lock, letting the owner keep the memory for a
//           second back-to-back access
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  r0_lock,
  input  logic                  r1_lock,
`endif
  input  logic                  r0_req,
  input  logic                  r0_rw,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_rw,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy,
  output logic                  owner
);
  state_t state, state_nx;
  logic   grant_valid, grant_id, lock;
  logic   grant;

  rr_pick2 u_pick (
    .req        ({r1_req, r0_req}),
    .last       (owner),
    .lock       (lock),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign grant = (state == ST_IDLE) && grant_valid;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q;
  // lock is sampled from the owner during RESP and consumed by the following grant
  always_ff @(posedge clk or posedge rst)
    if (rst)                   lock_q <= 1'b0;
    else if (state == ST_RESP) lock_q <= owner ? r1_lock : r0_lock;
    else if (grant)            lock_q <= 1'b0;
  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = (state == ST_IDLE)   ? (grant_valid ? ST_ACCESS : ST_IDLE) :
               (state == ST_ACCESS) ? ST_RESP : ST_IDLE;
    busy     = state != ST_IDLE;
    r0_ack   = (state == ST_RESP) && (owner == PORT_CPU);
    r1_ack   = (state == ST_RESP) && (owner == PORT_LDR);
    r0_rdata = mem_q;
    r1_rdata = mem_q;
  end

  // mem_rw is only ever high for the single ACCESS cycle, so each transaction writes at most once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_rw   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      owner    <= PORT_LDR;
    end else if (grant) begin
      owner    <= grant_id;
      mem_rw   <= grant_id ? r1_rw    : r0_rw;
      mem_addr <= grant_id ? r1_addr  : r0_addr;
      mem_data <= grant_id ? r1_wdata : r0_wdata;
    end else begin
      mem_rw   <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural memory and ack scoreboard
module tb_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        r0_req = 0, r0_rw = 0, r1_req = 0, r1_rw = 0;
  logic [15:0] r0_addr = 0, r1_addr = 0;
  logic [7:0]  r0_wdata = 0, r1_wdata = 0;
  logic        r0_ack, r1_ack, mem_rw, busy, owner;
  logic [7:0]  r0_rdata, r1_rdata, mem_data;
  logic [7:0]  mem_q = 8'h00;
  logic [15:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
  logic        r0_lock = 0, r1_lock = 0;
`endif

  typedef struct packed {logic port; logic rw; logic [7:0] data;} exp_t;
  exp_t       sb[$];
  int         checks = 0, failures = 0;
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
`ifdef MEM_ARB_LOCK_EN
    .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] = mem_data;
    else        mem_q <= mem[mem_addr];
  end

  always @(negedge clk) begin
    exp_t e;
    if (r0_ack || r1_ack) begin
      checks++;
      if (r0_ack && r1_ack) begin
        failures++; $display("FAIL both_acks: r0_ack=%0b r1_ack=%0b expected one", r0_ack, r1_ack);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL unexpected_ack: r0_ack=%0b r1_ack=%0b expected none", r0_ack, r1_ack);
      end else begin
        e = sb.pop_front();
        checks++;
        if (r1_ack !== e.port) begin
          failures++; $display("FAIL ack_port: got %0d expected %0d", r1_ack, e.port);
        end
        if (!e.rw) begin
          checks++;
          if ((r1_ack ? r1_rdata : r0_rdata) !== e.data) begin
            failures++;
            $display("FAIL rdata: got %0h expected %0h", (r1_ack ? r1_rdata : r0_rdata), e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic p, input logic rw, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.rw   = rw;
    e.data = rw ? 8'h00 : ref_mem[a];
    if (rw) ref_mem[a] = d;
    sb.push_back(e);
  endtask

  task automatic drive(input logic p, input logic rw, input logic [15:0] a, input logic [7:0] d);
    if (p) begin r1_rw = rw; r1_addr = a; r1_wdata = d; r1_req = 1; end
    else   begin r0_rw = rw; r0_addr = a; r0_wdata = d; r0_req = 1; end
    push_exp(p, rw, a, d);
  endtask

  task automatic run_single(input logic p, input logic rw, input logic [15:0] a, input logic [7:0] d,
                            input bit drop_early, output int rw_cyc, output int ack_cyc,
                            output int own_acks, output int other_acks);
    rw_cyc = 0; ack_cyc = 0; own_acks = 0; other_acks = 0;
    @(posedge clk); #1;
    drive(p, rw, a, d);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_rw) rw_cyc++;
      if (drop_early && c == 2) begin r0_req = 0; r1_req = 0; end
      if (p ? r1_ack : r0_ack) begin
        own_acks++;
        if (ack_cyc == 0) ack_cyc = c;
        r0_req = 0; r1_req = 0;
      end
      if (p ? r0_ack : r1_ack) other_acks++;
    end
  endtask

  task automatic do_reset();
    rst = 1; r0_req = 0; r1_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    checks++; if (owner !== 1'b1) begin failures++; $display("FAIL rst_owner: got %0b expected 1", owner); end
    checks++; if (mem_rw !== 1'b0) begin failures++; $display("FAIL rst_mem_rw: got %0b expected 0", mem_rw); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
    checks++; if (mem_data !== 8'h0) begin failures++; $display("FAIL rst_mem_data: got %0h expected 0", mem_data); end
    checks++; if ({r0_ack, r1_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks: got %b expected 00", {r0_ack, r1_ack}); end
  endtask

  task automatic test_write_read();
    int rwc, ackc, own, oth;
    run_single(1'b0, 1'b1, 16'h0010, 8'hA5, 0, rwc, ackc, own, oth);
    checks++; if (rwc != 1) begin failures++; $display("FAIL wr_rw_cycles: got %0d expected 1", rwc); end
    checks++; if (ackc != 3) begin failures++; $display("FAIL wr_ack_latency: got %0d expected 3", ackc); end
    checks++; if (own != 1) begin failures++; $display("FAIL wr_ack_count: got %0d expected 1", own); end
    checks++; if (mem[16'h0010] !== 8'hA5) begin failures++; $display("FAIL wr_mem: got %0h expected a5", mem[16'h0010]); end
    run_single(1'b0, 1'b0, 16'h0010, 8'h00, 0, rwc, ackc, own, oth);
    checks++; if (rwc != 0) begin failures++; $display("FAIL rd_rw_cycles: got %0d expected 0", rwc); end
    checks++; if (ackc != 3) begin failures++; $display("FAIL rd_ack_latency: got %0d expected 3", ackc); end
  endtask

  task automatic test_port1();
    int rwc, ackc, own, oth;
    run_single(1'b1, 1'b1, 16'h0020, 8'h3C, 0, rwc, ackc, own, oth);
    checks++; if (own != 1) begin failures++; $display("FAIL p1_ack_count: got %0d expected 1", own); end
    checks++; if (oth != 0) begin failures++; $display("FAIL p1_r0_ack: got %0d expected 0", oth); end
    checks++; if (owner !== 1'b1) begin failures++; $display("FAIL p1_owner: got %0b expected 1", owner); end
    run_single(1'b0, 1'b0, 16'h0020, 8'h00, 0, rwc, ackc, own, oth);
    checks++; if (oth != 0) begin failures++; $display("FAIL p0_r1_ack: got %0d expected 0", oth); end
  endtask

  task automatic test_alternate();
    logic order [4];
    logic own   [4];
    int   n = 0;
    do_reset();
    @(posedge clk); #1;
    r0_rw = 0; r0_addr = 16'h0000; r0_req = 1;
    r1_rw = 0; r1_addr = 16'h0001; r1_req = 1;
    push_exp(1'b0, 1'b0, 16'h0000, 8'h00);
    push_exp(1'b1, 1'b0, 16'h0001, 8'h00);
    push_exp(1'b0, 1'b0, 16'h0000, 8'h00);
    push_exp(1'b1, 1'b0, 16'h0001, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((r0_ack || r1_ack) && n < 4) begin
        order[n] = r1_ack; own[n] = owner; n++;
        if (n == 4) begin r0_req = 0; r1_req = 0; end
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL alt_count: got %0d expected 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (order[k] !== k[0]) begin failures++; $display("FAIL alt_order[%0d]: got %0b expected %0b", k, order[k], k[0]); end
      checks++;
      if (own[k] !== k[0]) begin failures++; $display("FAIL alt_owner[%0d]: got %0b expected %0b", k, own[k], k[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic order [2];
    int   n = 0;
    @(posedge clk); #1;
    r0_rw = 1; r0_addr = 16'h0030; r0_wdata = 8'hEE; r0_req = 1;
    @(posedge clk); #1;
    checks++; if ({busy, mem_rw} !== 2'b11) begin failures++; $display("FAIL mid_access: got %b expected 11", {busy, mem_rw}); end
    #2; rst = 1; r0_req = 0;
    #1;
    checks++; if (mem_rw !== 1'b0) begin failures++; $display("FAIL mid_mem_rw: got %0b expected 0", mem_rw); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (mem[16'h0030] !== 8'h00) begin failures++; $display("FAIL mid_no_write: got %0h expected 0", mem[16'h0030]); end
    @(negedge clk); rst = 0; #1;
    checks++; if (owner !== 1'b1) begin failures++; $display("FAIL mid_owner: got %0b expected 1", owner); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL mid_mem_addr: got %0h expected 0", mem_addr); end
    @(posedge clk); #1;
    r0_rw = 0; r0_addr = 16'h0030; r0_req = 1;
    r1_rw = 0; r1_addr = 16'h0001; r1_req = 1;
    push_exp(1'b0, 1'b0, 16'h0030, 8'h00);
    push_exp(1'b1, 1'b0, 16'h0001, 8'h00);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((r0_ack || r1_ack) && n < 2) begin
        order[n] = r1_ack; n++;
        if (n == 2) begin r0_req = 0; r1_req = 0; end
      end
    end
    checks++; if (n != 2) begin failures++; $display("FAIL mid_count: got %0d expected 2", n); end
    checks++; if (n == 2 && {order[0], order[1]} !== 2'b01) begin
      failures++; $display("FAIL mid_order: got %b expected 01", {order[0], order[1]});
    end
  endtask

  task automatic test_drop();
    int rwc, ackc, own, oth;
    run_single(1'b0, 1'b0, 16'h0010, 8'h00, 1, rwc, ackc, own, oth);
    checks++; if (own != 1) begin failures++; $display("FAIL drop_ack_count: got %0d expected 1", own); end
    checks++; if (ackc != 3) begin failures++; $display("FAIL drop_ack_latency: got %0d expected 3", ackc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy: got %0b expected 0", busy); end
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    logic order [3];
    int   n = 0;
    do_reset();
    @(posedge clk); #1;
    r0_rw = 0; r0_addr = 16'h0100; r0_req = 1; r0_lock = 1;
    r1_rw = 0; r1_addr = 16'h0001; r1_req = 1;
    push_exp(1'b0, 1'b0, 16'h0100, 8'h00);
    push_exp(1'b0, 1'b0, 16'h0101, 8'h00);
    push_exp(1'b1, 1'b0, 16'h0001, 8'h00);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((r0_ack || r1_ack) && n < 3) begin
        order[n] = r1_ack; n++;
        if (n == 1) r0_addr = 16'h0101;
        if (n == 2) begin r0_lock = 0; r0_addr = 16'h0102; end
        if (n == 3) begin r0_req = 0; r1_req = 0; end
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL lock_count: got %0d expected 3", n); end
    checks++; if (n == 3 && {order[0], order[1], order[2]} !== 3'b001) begin
      failures++; $display("FAIL lock_order: got %b expected 001", {order[0], order[1], order[2]});
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    mem[16'h0000] = 8'h11; ref_mem[16'h0000] = 8'h11;
    mem[16'h0001] = 8'h22; ref_mem[16'h0001] = 8'h22;
    mem[16'h0100] = 8'h5A; ref_mem[16'h0100] = 8'h5A;
    mem[16'h0101] = 8'hA6; ref_mem[16'h0101] = 8'hA6;
    test_reset();
    test_write_read();
    test_port1();
    test_alternate();
    test_reset_mid();
    test_drop();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
